// File: rtl/jt900h_muldiv.sv
// Iterative MUL/MULS/DIV/DIVS unit for the TLCS-900H core: one product or
// quotient bit per enabled clock, with sign fix-up and V-flag generation.
module jt900h_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [1:0]  sel,
  input  logic [2:0]  w,
  input  logic [31:0] op0,
  input  logic [31:0] op1,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout,
  output logic [2:0]  we,
  output logic        ovf,
  output logic        flag_we
);
  // Handshake: start is taken on a cen edge only while idle (busy low) and w
  // is legal; busy stays high up to the edge that raises done; done, we and
  // flag_we are high for exactly one cen cycle; dout holds until the next done.
  typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;
  state_t state, state_nx;

  logic [1:0]  sel_q;
  logic        word_q;
  logic [31:0] op0_q, a_mag, acc;
  logic [15:0] op1_q, b_mag, q;
  logic [3:0]  cnt;
  logic        neg_res, neg_rem, pre_ovf;

  logic is_div, is_signed, w_valid;
  assign is_div    = sel_q[1];
  assign is_signed = sel_q[0];
  assign w_valid   = (w == 3'b001) || (w == 3'b010);

  logic unused;
  assign unused = ^op1[31:16];

  // Operand magnitudes; the dividend is double width, the multiplicand is not
  logic        sgn_a, sgn_b, pre_chk;
  logic [31:0] a_raw, a_abs;
  logic [15:0] b_ext, b_abs, a_hi;
  assign sgn_a = is_signed & (is_div ? (word_q ? op0_q[31] : op0_q[15])
                                     : (word_q ? op0_q[15] : op0_q[7]));
  assign a_raw = is_div ? (word_q ? op0_q : {{16{sgn_a}}, op0_q[15:0]})
                        : (word_q ? {{16{sgn_a}}, op0_q[15:0]} : {{24{sgn_a}}, op0_q[7:0]});
  assign a_abs = sgn_a ? -a_raw : a_raw;
  assign sgn_b = is_signed & (word_q ? op1_q[15] : op1_q[7]);
  assign b_ext = word_q ? op1_q : {{8{sgn_b}}, op1_q[7:0]};
  assign b_abs = sgn_b ? -b_ext : b_ext;
  assign a_hi  = word_q ? a_abs[31:16] : {8'h00, a_abs[15:8]};
  assign pre_chk = is_div & (a_hi >= b_abs);

  // Both loops walk bit cnt from MSB down: multiplier bit or next dividend bit
  logic [16:0] trial;
  logic        fits;
  logic [15:0] diff;
  logic [31:0] mul_step;
  assign trial    = {acc[15:0], a_mag[{1'b0, cnt}]};
  assign fits     = trial >= {1'b0, b_mag};
  assign diff     = trial[15:0] - b_mag;
  assign mul_step = {acc[30:0], 1'b0} + (b_mag[cnt] ? a_mag : 32'h0);

  logic [15:0] quot_s, rem_s, q_lim;
  logic [31:0] prod_s;
  logic        post_chk, div_ovf;
  assign quot_s   = neg_res ? -q : q;
  assign rem_s    = neg_rem ? -acc[15:0] : acc[15:0];
  assign prod_s   = neg_res ? -acc : acc;
  assign q_lim    = word_q ? (neg_res ? 16'h8000 : 16'h7fff)
                           : (neg_res ? 16'h0080 : 16'h007f);
  assign post_chk = is_signed & (q > q_lim);
  assign div_ovf  = pre_ovf | post_chk;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && w_valid) state_nx = SETUP;
      SETUP:   state_nx = pre_chk ? FIX : ITER;
      ITER:    if (cnt == 4'd0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (cen) state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; done <= 1'b0; dout <= 32'h0; we <= 3'b000;
      ovf <= 1'b0; flag_we <= 1'b0;
      sel_q <= 2'b00; word_q <= 1'b0; op0_q <= 32'h0; op1_q <= 16'h0;
      a_mag <= 32'h0; b_mag <= 16'h0; acc <= 32'h0; q <= 16'h0; cnt <= 4'd0;
      neg_res <= 1'b0; neg_rem <= 1'b0; pre_ovf <= 1'b0;
    end else if (cen) begin
      done    <= 1'b0;
      we      <= 3'b000;
      flag_we <= 1'b0;
      busy    <= (state_nx != IDLE);
      case (state)
        IDLE: if (start && w_valid) begin
          sel_q <= sel; word_q <= w[1]; op0_q <= op0; op1_q <= op1[15:0];
        end
        SETUP: begin
          a_mag   <= a_abs;
          b_mag   <= b_abs;
          neg_res <= sgn_a ^ sgn_b;
          neg_rem <= sgn_a;
          pre_ovf <= pre_chk;
          acc     <= is_div ? {16'h0, a_hi} : 32'h0;
          q       <= 16'h0;
          cnt     <= word_q ? 4'd15 : 4'd7;
        end
        ITER: begin
          cnt <= cnt - 4'd1;
          if (is_div) begin
            acc <= {16'h0, fits ? diff : trial[15:0]};
            q   <= {q[14:0], fits};
          end else begin
            acc <= mul_step;
          end
        end
        FIX: begin
          done <= 1'b1;
          if (is_div) begin
            flag_we <= 1'b1;
            ovf     <= div_ovf;
            if (div_ovf) begin
              dout <= op0_q;
            end else begin
              dout <= word_q ? {rem_s, quot_s} : {16'h0, rem_s[7:0], quot_s[7:0]};
              we   <= word_q ? 3'b100 : 3'b010;
            end
          end else begin
            ovf  <= 1'b0;
            dout <= word_q ? prod_s : {16'h0, prod_s[15:0]};
            we   <= word_q ? 3'b100 : 3'b010;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_jt900h_muldiv.sv
// Directed-vector bench for jt900h_muldiv: table of operations with
// hand-computed results plus sequences for cen stalls, resets and stray starts.
module tb_jt900h_muldiv;
  logic        clk = 1'b0;
  logic        rst, cen, start;
  logic [1:0]  sel;
  logic [2:0]  w;
  logic [31:0] op0, op1;
  logic        busy, done, ovf, flag_we;
  logic [31:0] dout;
  logic [2:0]  we;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  jt900h_muldiv dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .sel(sel), .w(w),
    .op0(op0), .op1(op1), .busy(busy), .done(done), .dout(dout), .we(we),
    .ovf(ovf), .flag_we(flag_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  w;
    logic [31:0] op0;
    logic [31:0] op1;
    int          lat;
    logic [31:0] dout;
    logic [2:0]  we;
    logic        ovf;
    logic        fwe;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at #1 after a clock edge; returns with the done cycle sampled
  task automatic run_op(input logic [1:0] s, input logic [2:0] ww,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic bz1);
    sel = s; w = ww; op0 = a; op1 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bz1 = busy;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  initial begin
    int   lat, ndone;
    logic bz1;
    logic [31:0] e;

    vecs[0]  = '{2'b00, 3'b001, 32'h000000FF, 32'h000000FF, 10, 32'h0000FE01, 3'b010, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 3'b010, 32'h00008000, 32'h00000002, 18, 32'hFFFF0000, 3'b100, 1'b0, 1'b0};
    vecs[2]  = '{2'b10, 3'b010, 32'h00012345, 32'h00000010, 18, 32'h00051234, 3'b100, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, 3'b001, 32'h00000064, 32'h00000000,  2, 32'h00000064, 3'b000, 1'b1, 1'b1};
    vecs[4]  = '{2'b11, 3'b001, 32'h0000FFF9, 32'h00000002, 10, 32'h0000FFFD, 3'b010, 1'b0, 1'b1};
    vecs[5]  = '{2'b11, 3'b001, 32'h0000FF80, 32'h000000FF, 10, 32'h0000FF80, 3'b000, 1'b1, 1'b1};
    vecs[6]  = '{2'b01, 3'b001, 32'h00000080, 32'h00000080, 10, 32'h00004000, 3'b010, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 3'b001, 32'h00000003, 32'h000000FE, 10, 32'h0000FFFA, 3'b010, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 3'b010, 32'h0000FFFF, 32'h0000FFFF, 18, 32'hFFFE0001, 3'b100, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 3'b010, 32'hFFFF8000, 32'h00000001, 18, 32'h00008000, 3'b100, 1'b0, 1'b1};
    vecs[10] = '{2'b11, 3'b010, 32'h00008000, 32'h00000001, 18, 32'h00008000, 3'b000, 1'b1, 1'b1};
    vecs[11] = '{2'b10, 3'b010, 32'h00100000, 32'h00000010,  2, 32'h00100000, 3'b000, 1'b1, 1'b1};
    vecs[12] = '{2'b11, 3'b010, 32'hFFFFFFF9, 32'h0000FFFE, 18, 32'hFFFF0003, 3'b100, 1'b0, 1'b1};
    vecs[13] = '{2'b10, 3'b001, 32'h000000FF, 32'h00000010, 10, 32'h00000F0F, 3'b010, 1'b0, 1'b1};
    vecs[14] = '{2'b10, 3'b001, 32'h00000FFF, 32'h00000010, 10, 32'h00000FFF, 3'b010, 1'b0, 1'b1};

    // Reset
    rst = 1'b1; cen = 1'b1; start = 1'b0; sel = 2'b00; w = 3'b001; op0 = 32'h0; op1 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_we", {29'h0, we}, 32'h0);
    check("rst_ovf", {31'h0, ovf}, 32'h0);
    check("rst_flag_we", {31'h0, flag_we}, 32'h0);

    // Table-driven operations
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(vecs[i].dout);
      run_op(vecs[i].sel, vecs[i].w, vecs[i].op0, vecs[i].op1, lat, bz1);
      e = exp_q.pop_front();
      check($sformatf("v%0d_busy", i), {31'h0, bz1}, 32'h1);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_dout", i), dout, e);
      check($sformatf("v%0d_we", i), {29'h0, we}, {29'h0, vecs[i].we});
      check($sformatf("v%0d_ovf", i), {31'h0, ovf}, {31'h0, vecs[i].ovf});
      check($sformatf("v%0d_flag_we", i), {31'h0, flag_we}, {31'h0, vecs[i].fwe});
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse", i), {busy, done, we, flag_we}, 32'h0);
      check($sformatf("v%0d_hold", i), dout, e);
    end

    // Illegal widths are ignored
    for (int k = 0; k < 2; k++) begin
      sel = 2'b00; w = (k == 0) ? 3'b100 : 3'b000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("badw%0d_busy", k), {31'h0, busy}, 32'h0);
      ndone = 0;
      repeat (12) begin @(posedge clk); #1; if (done) ndone++; end
      check($sformatf("badw%0d_done", k), ndone, 0);
    end

    // Start pulses while busy do not launch another operation
    sel = 2'b00; w = 3'b001; op0 = 32'hFF; op1 = 32'hFF; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      start = (i == 3 || i == 6);
      @(posedge clk); #1;
      if (done) begin ndone++; lat = i; end
    end
    start = 1'b0;
    check("busy_start_ndone", ndone, 1);
    check("busy_start_lat", lat, 10);

    // cen low for 5 clocks mid-ITER stretches latency by 5
    sel = 2'b00; w = 3'b010; op0 = 32'hFFFF; op1 = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    cen = 1'b0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    check("cen_busy_frozen", {31'h0, busy}, 32'h1);
    cen = 1'b1;
    while (lat < 200) begin @(posedge clk); #1; lat++; if (done) break; end
    check("cen_lat", lat, 23);
    check("cen_dout", dout, 32'hFFFE0001);
    check("cen_we", {29'h0, we}, 32'h4);

    // Reset during ITER aborts without done; a fresh start then works
    @(posedge clk); #1;
    sel = 2'b10; w = 3'b010; op0 = 32'h00012345; op1 = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_dout", dout, 32'h0);
    ndone = 0;
    repeat (25) begin @(posedge clk); #1; if (done) ndone++; end
    check("abort_ndone", ndone, 0);
    run_op(2'b10, 3'b010, 32'h00012345, 32'h10, lat, bz1);
    check("after_abort_lat", lat, 18);
    check("after_abort_dout", dout, 32'h00051234);
    check("after_abort_flag_we", {31'h0, flag_we}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
